// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bus and transmitter start/busy/done handshake for uart_tx_arbiter.
// The master modport is the arbiter side; slave is the requesters plus TX engine.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// The grant is held across a packet until req_last, with an optional stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned  NUM_REQ      = 4,
  parameter int unsigned  LOCK_TIMEOUT = 1024,
  localparam int unsigned ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  uart_tx_arbiter_if.master   bus,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                lock_active,
  output logic                timeout_pulse
);

  localparam int unsigned CNT_WIDTH = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'((LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1);
  localparam logic [ID_WIDTH-1:0] ID_MAX = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_q, rr_d;
  logic [ID_WIDTH-1:0]  grant_q, grant_d;
  logic                 lock_q, lock_d;
  logic                 last_q, last_d;
  logic                 pulse_q, pulse_d;
  logic [7:0]           data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 sel_found;
  logic [ID_WIDTH-1:0]  sel_idx;
  logic [7:0]           sel_data;
  logic                 sel_last;
  logic [ID_WIDTH-1:0]  next_id;
  logic [NUM_REQ-1:0]   ready;
  logic                 start;

  // Offsets are walked high to low so the requester closest to rr_q wins.
  always_comb begin : arbitrate
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = grant_q;
    if (lock_q) begin
      sel_found = bus.req_valid[grant_q];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.req_valid[ID_WIDTH'(idx)]) begin
          sel_found = 1'b1;
          sel_idx   = ID_WIDTH'(idx);
        end
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == ID_WIDTH'(i)) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_last = bus.req_last[i];
        ready[i] = reset_n && (state_q == StIdle) && sel_found;
      end
    end
  end

  assign next_id = (grant_q == ID_MAX) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          data_d  = sel_data;
          grant_d = sel_idx;
          last_d  = sel_last;
          lock_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIssue;
        end else if (lock_q && (LOCK_TIMEOUT != 0)) begin
          if (cnt_q == CNT_LAST) begin
            lock_d  = 1'b0;
            rr_d    = next_id;
            pulse_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        if (!bus.tx_busy) begin
          start   = 1'b1;
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus.tx_done) begin
          state_d = StIdle;
          if (last_q) begin
            lock_d = 1'b0;
            rr_d   = next_id;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      pulse_q <= 1'b0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.tx_start   = start;
  assign bus.tx_data    = data_q;
  assign grant_id       = grant_q;
  assign lock_active    = lock_q;
  assign timeout_pulse  = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a transaction-level model compared every cycle,
// plus hand-computed grant orders, byte orders, latencies and reset values.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] grant_id;
  logic       lock_active;
  logic       timeout_pulse;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .grant_id      (grant_id),
    .lock_active   (lock_active),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  int grant_log[$];
  int byte_log[$];
  int cyc = 0, accept_cyc = 0, start_cyc = 0, done_cyc = 0, pulse_cyc = 0;
  int n_starts = 0, n_pulses = 0;
  bit start_seen = 0;
  int tx_len = 10, eng_cnt = 0, hold_until = 0;

  // Transmitter stand-in: busy for tx_len cycles after a start, done on the last one.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (!reset_n) begin
      eng_cnt     = 0;
      bus.tx_busy = 1'b0;
      bus.tx_done = 1'b0;
    end else begin
      if (start_seen) eng_cnt = tx_len;
      else if (eng_cnt > 0) eng_cnt--;
      bus.tx_busy = (eng_cnt > 0) || (cyc < hold_until);
      bus.tx_done = (eng_cnt == 1);
    end
  end

  // Model: phase 0 waits for a byte, 1 holds a byte not yet launched, 2 awaits done.
  int m_rr = 0, m_gid = 0, m_phase = 0, m_stall = 0, m_byte = 0;
  bit m_locked = 0, m_last = 0, m_pulse = 0;

  always @(negedge clock) begin
    int sel;
    int exp_ready;
    bit exp_start;
    bit nxt_pulse;
    if (!reset_n) begin
      m_rr = 0; m_gid = 0; m_phase = 0; m_stall = 0; m_byte = 0;
      m_locked = 0; m_last = 0; m_pulse = 0;
    end
    sel = -1;
    if (reset_n && m_phase == 0) begin
      if (m_locked) begin
        if (bus.req_valid[m_gid]) sel = m_gid;
      end else begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && bus.req_valid[(m_rr + k) % N]) sel = (m_rr + k) % N;
      end
    end
    exp_ready = (sel >= 0) ? (1 << sel) : 0;
    exp_start = reset_n && (m_phase == 1) && !bus.tx_busy;
    chk("req_ready", int'(bus.req_ready), exp_ready);
    chk("tx_start", int'(bus.tx_start), int'(exp_start));
    chk("tx_data", int'(bus.tx_data), m_byte);
    chk("grant_id", int'(grant_id), m_gid);
    chk("lock_active", int'(lock_active), int'(m_locked));
    chk("timeout_pulse", int'(timeout_pulse), int'(m_pulse));

    if (bus.req_ready != '0) begin
      for (int k = 0; k < N; k++) if (bus.req_ready[k]) grant_log.push_back(k);
      accept_cyc = cyc;
    end
    if (bus.tx_start) begin
      byte_log.push_back(int'(bus.tx_data));
      start_cyc = cyc;
      n_starts++;
    end
    if (reset_n && bus.tx_done) done_cyc = cyc;
    if (timeout_pulse) begin
      pulse_cyc = cyc;
      n_pulses++;
    end
    start_seen = bus.tx_start;

    if (reset_n) begin
      nxt_pulse = 0;
      if (sel >= 0) begin
        m_byte   = int'(bus.req_data[8*sel +: 8]);
        m_gid    = sel;
        m_last   = bus.req_last[sel];
        m_locked = 1;
        m_phase  = 1;
        m_stall  = 0;
      end else if (m_phase == 0) begin
        if (m_locked) begin
          m_stall++;
          if (m_stall == TO) begin
            m_locked  = 0;
            m_rr      = (m_gid + 1) % N;
            nxt_pulse = 1;
            m_stall   = 0;
          end
        end
      end else if (m_phase == 1) begin
        if (!bus.tx_busy) m_phase = 2;
      end else if (bus.tx_done) begin
        m_phase = 0;
        if (m_last) begin
          m_locked = 0;
          m_rr     = (m_gid + 1) % N;
        end
      end
      m_pulse = nxt_pulse;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_grants(input int target, input int limit);
    int n = 0;
    while (grant_log.size() < target && n < limit) begin
      settle();
      n++;
    end
    if (grant_log.size() < target) chk("grant_wait", grant_log.size(), target);
  endtask

  task automatic wait_unlocked(input int limit);
    int n = 0;
    while (lock_active && n < limit) begin
      settle();
      n++;
    end
    if (lock_active) chk("unlock_wait", int'(lock_active), 0);
  endtask

  task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
    bus.req_valid[i]       = v;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i]        = l;
  endtask

  initial begin
    int b, bb, s0, p0, n;
    int exp_fair[5]  = '{0, 1, 2, 3, 0};
    int exp_fbyte[5] = '{'h11, 'h22, 'h33, 'h44, 'h11};
    int exp_pkt[6]   = '{1, 1, 1, 2, 3, 0};
    int exp_pbyte[6] = '{'h11, 'h22, 'h33, 'h77, 'h88, 'h5A};

    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.req_last  = '0;
    repeat (3) tick();
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_start", int'(bus.tx_start), 0);
    chk("rst_data", int'(bus.tx_data), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_lock", int'(lock_active), 0);
    chk("rst_pulse", int'(timeout_pulse), 0);
    bus.req_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();

    // Fairness: everyone valid with single-byte packets.
    b = grant_log.size(); bb = byte_log.size();
    set_req(0, 1, 8'h11, 1); set_req(1, 1, 8'h22, 1);
    set_req(2, 1, 8'h33, 1); set_req(3, 1, 8'h44, 1);
    wait_grants(b + 5, 100);
    tick();
    bus.req_valid = '0;
    wait_unlocked(40);
    for (int i = 0; i < 5; i++) chk("fair_order", grant_log[b+i], exp_fair[i]);
    for (int i = 0; i < 5; i++) chk("fair_bytes", byte_log[bb+i], exp_fbyte[i]);

    // Single requester: ready in T, start with the byte in T+1.
    tick();
    b = grant_log.size();
    set_req(2, 1, 8'hA5, 1);
    wait_grants(b + 1, 20);
    chk("single_ready", int'(bus.req_ready), 'b0100);
    tick();
    bus.req_valid = '0;
    settle();
    chk("single_start", int'(bus.tx_start), 1);
    chk("single_data", int'(bus.tx_data), 'hA5);
    wait_unlocked(40);
    tick();
    set_req(0, 1, 8'h11, 1); set_req(1, 1, 8'h22, 1);
    set_req(2, 1, 8'h33, 1); set_req(3, 1, 8'h44, 1);
    wait_grants(b + 3, 60);
    tick();
    bus.req_valid = '0;
    wait_unlocked(40);
    chk("rr_after_single", grant_log[b+1], 3);
    chk("rr_wrap", grant_log[b+2], 0);

    // Packet lock: requester 1 holds the grant for three bytes.
    tick();
    b = grant_log.size(); bb = byte_log.size();
    set_req(0, 1, 8'h5A, 1); set_req(1, 1, 8'h11, 0);
    set_req(2, 1, 8'h77, 1); set_req(3, 1, 8'h88, 1);
    wait_grants(b + 1, 20);
    tick();
    set_req(1, 1, 8'h22, 0);
    wait_grants(b + 2, 40);
    tick();
    set_req(1, 1, 8'h33, 1);
    wait_grants(b + 3, 40);
    tick();
    set_req(1, 0, 8'h33, 1);
    wait_grants(b + 6, 80);
    tick();
    bus.req_valid = '0;
    wait_unlocked(40);
    for (int i = 0; i < 6; i++) chk("pkt_order", grant_log[b+i], exp_pkt[i]);
    for (int i = 0; i < 6; i++) chk("pkt_bytes", byte_log[bb+i], exp_pbyte[i]);

    // Timeout: requester 3 stalls mid-packet while 0 and 1 wait.
    tick();
    b = grant_log.size();
    p0 = n_pulses;
    set_req(3, 1, 8'hC3, 0);
    wait_grants(b + 1, 20);
    tick();
    set_req(3, 0, 8'hC3, 0);
    set_req(0, 1, 8'h01, 1);
    set_req(1, 1, 8'h02, 1);
    n = 0;
    while (n_pulses == p0 && n < 80) begin
      settle();
      n++;
    end
    chk("to_seen", n_pulses - p0, 1);
    chk("to_gap", pulse_cyc - done_cyc, 9);
    chk("to_unlocked", int'(lock_active), 0);
    chk("to_ready", int'(bus.req_ready), 'b0001);
    chk("to_next_grant", grant_log[b+1], 0);
    tick();
    bus.req_valid = '0;
    wait_unlocked(40);

    // Busy gating: transmitter busy for five cycles after acceptance.
    tick();
    b = grant_log.size();
    s0 = n_starts;
    hold_until = cyc + 6;
    set_req(1, 1, 8'h3C, 1);
    wait_grants(b + 1, 20);
    tick();
    bus.req_valid = '0;
    wait_unlocked(60);
    chk("busy_delay", start_cyc - accept_cyc, 6);
    chk("busy_once", n_starts - s0, 1);
    chk("busy_byte", byte_log[byte_log.size()-1], 'h3C);

    // Reset while a locked packet is in flight.
    tick();
    b = grant_log.size();
    s0 = n_starts;
    set_req(2, 1, 8'h99, 0);
    wait_grants(b + 1, 20);
    tick();
    bus.req_valid = '0;
    n = 0;
    while (n_starts == s0 && n < 20) begin
      settle();
      n++;
    end
    @(posedge clock);
    #3;
    chk("pre_rst_lock", int'(lock_active), 1);
    chk("pre_rst_grant", int'(grant_id), 2);
    reset_n = 1'b0;
    #1;
    chk("async_start", int'(bus.tx_start), 0);
    chk("async_lock", int'(lock_active), 0);
    chk("async_grant", int'(grant_id), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    b = grant_log.size();
    set_req(0, 1, 8'h11, 1); set_req(1, 1, 8'h22, 1);
    set_req(2, 1, 8'h33, 1); set_req(3, 1, 8'h44, 1);
    wait_grants(b + 1, 20);
    chk("post_rst_grant", grant_log[b], 0);
    tick();
    bus.req_valid = '0;
    wait_unlocked(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmit engine between NUM_REQ byte-stream requesters (status reporter, echo path, debug dump, ...).
- Accepts bytes over a valid/ready handshake and sequences the transmitter via a start/busy/done handshake.
- Holds the grant across a multi-byte packet until req_last, with a timeout that releases a stalled lock.
- Sits between requesters and the serial TX datapath, alongside uart_receive.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 1024, idle cycles a locked requester may stall before the lock is dropped; 0 disables the timeout.
- ID_WIDTH, localparam, max(1, $clog2(NUM_REQ)).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  requester i presents a byte.
- req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- req_last  input  NUM_REQ  byte of requester i is the last byte of its packet.
- req_ready  output  NUM_REQ  one-hot; the byte of requester i is accepted this cycle.
- tx_start  output  1  one-cycle pulse; transmitter loads tx_data.
- tx_data  output  8  registered byte to transmit.
- tx_busy  input  1  transmitter is shifting a frame.
- tx_done  input  1  one-cycle pulse at end of the stop bit.
- grant_id  output  ID_WIDTH  index of the current or last granted requester.
- lock_active  output  1  a packet is in progress; the grant is held.
- timeout_pulse  output  1  one-cycle pulse when a lock is dropped by timeout.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, grant_id=0, lock_active=0, tx_start=0, tx_data=8'h00, timeout counter=0, timeout_pulse=0, req_ready=0. Asserting reset mid-frame drops tx_start and the lock immediately. No byte is replayed.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, unlocked:
  - Select the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[sel]=1 combinationally in the same cycle.
  - On that edge: tx_data<=req_data[sel], grant_id<=sel, last_q<=req_last[sel], lock_active<=1, state<=ISSUE.
  - If no req_valid is set, remain in IDLE.
- IDLE, locked:
  - Only requester grant_id is eligible; other req_valid bits are ignored.
  - If req_valid[grant_id]=1: accept exactly as above and clear the timeout counter.
  - Otherwise the counter increments each cycle. When it reaches LOCK_TIMEOUT:
    - lock_active<=0, rr_ptr<=grant_id+1 mod NUM_REQ, timeout_pulse=1 for one cycle, counter<=0.
    - Arbitration resumes the following cycle.
- ISSUE: tx_start=1 only while tx_busy=0; the cycle it fires, state<=WAIT_DONE. tx_start is never asserted while tx_busy=1.
- WAIT_DONE: on tx_done, state<=IDLE.
  - If last_q=1: lock_active<=0, rr_ptr<=grant_id+1 mod NUM_REQ.
  - Otherwise the lock is held.
  - A tx_done seen in IDLE or ISSUE is ignored.
- Latency: req_ready in cycle T, tx_start at T+1 when the transmitter is idle. The next byte can be accepted in the cycle after tx_done.
- At most one req_ready bit is high per cycle. req_ready is never high outside IDLE.
- Single-byte packets (req_last=1 on the first byte) still set lock_active from acceptance until tx_done.
- rr_ptr wraps from NUM_REQ-1 to 0.
- The timeout counter is $clog2(LOCK_TIMEOUT+1) bits wide and saturates. It does not count outside IDLE.

Test Plan:
- Single requester: req 2 sends 8'hA5 with last=1, tx_busy=0 → req_ready=4'b0100 in cycle T, tx_start and tx_data=A5 at T+1. After tx_done: lock_active=0, rr_ptr=3.
- Fairness: all four valid, single-byte packets, tx_done 10 cycles after each start → grant order 0,1,2,3,0. No requester is granted twice before the others are served.
- Packet lock: req 1 sends 3 bytes (last on the 3rd) while req 0 is continuously valid → bytes 11,22,33 from req 1 go out back-to-back, then req 2/3/0 are served. req_ready[0] stays 0 throughout.
- Timeout: LOCK_TIMEOUT=8; req 3 sends one byte with last=0, then drops valid → timeout_pulse exactly 8 cycles after returning to IDLE, lock_active=0, next grant goes to req 0.
- Busy gating: tx_busy=1 held for 5 cycles after acceptance → tx_start is delayed until the first cycle tx_busy=0, and occurs exactly once.
- Reset mid-packet: assert reset_n=0 in WAIT_DONE with a lock held → tx_start=0, lock_active=0, grant_id=0 asynchronously. After release, req 0 has priority.
